// File: rtl/demux32_1x8_slots_pkg.sv
// Shared constants and helpers for the 1-to-8 32-bit slot demultiplexer.
package demux32_1x8_slots_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NSLOTS    = 8;

    localparam logic [2:0] SLOT_A = 3'd0;
    localparam logic [2:0] SLOT_B = 3'd1;
    localparam logic [2:0] SLOT_C = 3'd2;
    localparam logic [2:0] SLOT_D = 3'd3;
    localparam logic [2:0] SLOT_E = 3'd4;
    localparam logic [2:0] SLOT_F = 3'd5;
    localparam logic [2:0] SLOT_G = 3'd6;
    localparam logic [2:0] SLOT_H = 3'd7;

    // Number of set bits in an occupancy vector (0..NSLOTS).
    function automatic logic [3:0] popcount_slots(input logic [NSLOTS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/demux32_1x8_slots_slot.sv
// One holding slot: a data register plus its EMPTY/FULL occupancy flag.
module demux_slot
    import demux32_1x8_slots_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,     // decoded and already qualified by in_ready
    input  logic [WIDTH-1:0] din,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // Load on write (refill wins over ack); ack alone frees the slot but keeps the data.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every slot samples
        // the same pre-edge values regardless of evaluation order.
        if (reset) begin
            // NOTE: the data register is reset too, because the slot outputs are
            // architecturally visible and must read zero after reset.
            r_data <= '0;
            r_full <= 1'b0;
        end else if (wr) begin
            r_data <= din;
            r_full <= 1'b1;
        end else if (ack) begin
            r_full <= 1'b0;
        end
    end

    assign dout = r_data;
    assign full = r_full;

endmodule

// File: rtl/demux32_1x8_slots.sv
// Steers one producer word into one of eight back-pressured holding slots.
module demux32_1x8_slots
    import demux32_1x8_slots_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [2:0]        sel,
    input  logic              wr_en,
    output logic              in_ready,
    input  logic [NSLOTS-1:0] ack,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [WIDTH-1:0]  out_c,
    output logic [WIDTH-1:0]  out_d,
    output logic [WIDTH-1:0]  out_e,
    output logic [WIDTH-1:0]  out_f,
    output logic [WIDTH-1:0]  out_g,
    output logic [WIDTH-1:0]  out_h,
    output logic [NSLOTS-1:0] full,
    output logic [3:0]        count,
    output logic              overrun
);

    logic [NSLOTS-1:0] w_sel_onehot;
    logic [NSLOTS-1:0] w_wr;
    logic [NSLOTS-1:0] w_full;
    logic [NSLOTS-1:0] w_full_nxt;
    logic              w_accept;
    logic              w_reject;
    logic [WIDTH-1:0]  w_dout [NSLOTS];
    logic [3:0]        r_count;
    logic              r_overrun;

    // A full slot being acked this cycle can take a refill in the same cycle.
    assign in_ready = ~w_full[sel] | ack[sel];
    assign w_accept = wr_en & in_ready;
    assign w_reject = wr_en & ~in_ready;

    // Decode sel into a one-hot write strobe, gated by acceptance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_sel_onehot      = '0;
        w_sel_onehot[sel] = 1'b1;
        w_wr              = w_accept ? w_sel_onehot : '0;
    end

    // Occupancy after this edge, used so count moves on the same edge as full.
    assign w_full_nxt = w_wr | (w_full & ~ack);

    for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .reset (reset),
            .wr    (w_wr[i]),
            .din   (in_data),
            .ack   (ack[i]),
            .dout  (w_dout[i]),
            .full  (w_full[i])
        );
    end

    // Registered occupancy count, tracking the next-state popcount of full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= popcount_slots(w_full_nxt);
        end
    end

    // Sticky overrun: a rejected write sets it, and setting beats clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_reject) begin
            r_overrun <= 1'b1;
        end else if (clr_err) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_a   = w_dout[SLOT_A];
    assign out_b   = w_dout[SLOT_B];
    assign out_c   = w_dout[SLOT_C];
    assign out_d   = w_dout[SLOT_D];
    assign out_e   = w_dout[SLOT_E];
    assign out_f   = w_dout[SLOT_F];
    assign out_g   = w_dout[SLOT_G];
    assign out_h   = w_dout[SLOT_H];
    assign full    = w_full;
    assign count   = r_count;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_demux32_1x8_slots.sv
// Directed table plus randomized stimulus against a slot-level reference model.
module tb_demux32_1x8_slots;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic [2:0]  sel;
    logic        wr_en;
    logic        in_ready;
    logic [7:0]  ack;
    logic        clr_err;
    logic [31:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic [7:0]  full;
    logic [3:0]  count;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    demux32_1x8_slots dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .sel      (sel),
        .wr_en    (wr_en),
        .in_ready (in_ready),
        .ack      (ack),
        .clr_err  (clr_err),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_d    (out_d),
        .out_e    (out_e),
        .out_f    (out_f),
        .out_g    (out_g),
        .out_h    (out_h),
        .full     (full),
        .count    (count),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] outs [8];
    assign outs[0] = out_a;
    assign outs[1] = out_b;
    assign outs[2] = out_c;
    assign outs[3] = out_d;
    assign outs[4] = out_e;
    assign outs[5] = out_f;
    assign outs[6] = out_g;
    assign outs[7] = out_h;

    // Reference model: what each consumer would see, kept as plain arrays.
    logic [31:0] m_data [8];
    bit          m_full [8];
    bit          m_ovr;

    function automatic bit model_ready(input logic [2:0] s, input logic [7:0] a);
        return !m_full[s] || a[s];
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_full[i];
        return c;
    endfunction

    function automatic logic [7:0] model_full_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_full[i];
        return v;
    endfunction

    task automatic model_step(input logic r, input logic we, input logic [2:0] s,
                              input logic [31:0] d, input logic [7:0] a, input logic c);
        bit rdy;
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_data[i] = '0;
                m_full[i] = 0;
            end
            m_ovr = 0;
        end else begin
            rdy = model_ready(s, a);
            for (int i = 0; i < 8; i++) begin
                if (we && rdy && s == 3'(i)) begin
                    m_data[i] = d;
                    m_full[i] = 1;
                end else if (a[i]) begin
                    m_full[i] = 0;
                end
            end
            if (we && !rdy) m_ovr = 1;
            else if (c) m_ovr = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, sampling in_ready mid-cycle.
    task automatic drive(input logic r, input logic we, input logic [2:0] s,
                         input logic [31:0] d, input logic [7:0] a, input logic c,
                         output logic rdy_seen);
        @(negedge clk);
        reset   = r;
        wr_en   = we;
        sel     = s;
        in_data = d;
        ack     = a;
        clr_err = c;
        #1;
        rdy_seen = in_ready;
        @(posedge clk);
        model_step(r, we, s, d, a, c);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  sel;
        logic [31:0] d;
        logic [7:0]  ack;
        logic        clr;
        logic        chk_rdy;
        logic        exp_rdy;
        logic [7:0]  exp_full;
        logic [3:0]  exp_count;
        logic        exp_ovr;
        logic [2:0]  chk_slot;
        logic [31:0] chk_val;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic rdy;
        string tag;

        reset = 1'b1; wr_en = 1'b0; sel = '0; in_data = '0; ack = '0; clr_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_data[i] = '0;
            m_full[i] = 0;
        end
        m_ovr = 0;

        //                 rst we sel data          ack    clr rdy? rdy full   cnt ovr slot value
        tbl.push_back(vec_t'{1, 0, 0, 32'h0,        8'h00, 0,  0,   0,  8'h00, 0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{0, 1, 3, 32'hDEADBEEF, 8'h00, 0,  1,   1,  8'h08, 1,  0,  3, 32'hDEADBEEF});
        tbl.push_back(vec_t'{0, 0, 0, 32'h0,        8'h00, 0,  1,   1,  8'h08, 1,  0,  0, 32'h0});
        tbl.push_back(vec_t'{0, 0, 7, 32'h0,        8'h00, 0,  1,   1,  8'h08, 1,  0,  7, 32'h0});
        tbl.push_back(vec_t'{0, 1, 0, 32'h1,        8'h00, 0,  1,   1,  8'h09, 2,  0,  0, 32'h1});
        tbl.push_back(vec_t'{0, 1, 1, 32'h2,        8'h00, 0,  1,   1,  8'h0B, 3,  0,  1, 32'h2});
        tbl.push_back(vec_t'{0, 1, 2, 32'h3,        8'h00, 0,  1,   1,  8'h0F, 4,  0,  2, 32'h3});
        tbl.push_back(vec_t'{0, 1, 3, 32'h4,        8'h08, 0,  1,   1,  8'h0F, 4,  0,  3, 32'h4});
        tbl.push_back(vec_t'{0, 1, 4, 32'h5,        8'h00, 0,  1,   1,  8'h1F, 5,  0,  4, 32'h5});
        tbl.push_back(vec_t'{0, 1, 5, 32'h6,        8'h00, 0,  1,   1,  8'h3F, 6,  0,  5, 32'h6});
        tbl.push_back(vec_t'{0, 1, 6, 32'h7,        8'h00, 0,  1,   1,  8'h7F, 7,  0,  6, 32'h7});
        tbl.push_back(vec_t'{0, 1, 7, 32'h8,        8'h00, 0,  1,   1,  8'hFF, 8,  0,  7, 32'h8});
        tbl.push_back(vec_t'{0, 1, 5, 32'hFFFFFFFF, 8'h00, 0,  1,   0,  8'hFF, 8,  1,  5, 32'h6});
        tbl.push_back(vec_t'{0, 0, 5, 32'h0,        8'h00, 0,  1,   0,  8'hFF, 8,  1,  5, 32'h6});
        tbl.push_back(vec_t'{0, 0, 0, 32'h0,        8'h00, 1,  1,   0,  8'hFF, 8,  0,  5, 32'h6});
        tbl.push_back(vec_t'{0, 1, 2, 32'hAAAA0000, 8'h04, 0,  1,   1,  8'hFF, 8,  0,  2, 32'hAAAA0000});
        tbl.push_back(vec_t'{0, 1, 2, 32'h5555,     8'h04, 0,  1,   1,  8'hFF, 8,  0,  2, 32'h5555});
        tbl.push_back(vec_t'{0, 0, 0, 32'h0,        8'hFF, 0,  1,   1,  8'h00, 0,  0,  0, 32'h1});
        tbl.push_back(vec_t'{0, 0, 1, 32'h0,        8'h00, 0,  1,   1,  8'h00, 0,  0,  1, 32'h2});
        tbl.push_back(vec_t'{0, 0, 2, 32'h0,        8'h00, 0,  1,   1,  8'h00, 0,  0,  2, 32'h5555});
        tbl.push_back(vec_t'{0, 0, 6, 32'h0,        8'h00, 0,  1,   1,  8'h00, 0,  0,  6, 32'h7});
        tbl.push_back(vec_t'{0, 0, 7, 32'h0,        8'h00, 0,  1,   1,  8'h00, 0,  0,  7, 32'h8});
        tbl.push_back(vec_t'{0, 1, 1, 32'hCAFE,     8'h40, 0,  1,   1,  8'h02, 1,  0,  1, 32'hCAFE});
        tbl.push_back(vec_t'{0, 1, 1, 32'hBEEF,     8'h00, 1,  1,   0,  8'h02, 1,  1,  1, 32'hCAFE});
        tbl.push_back(vec_t'{1, 1, 0, 32'h12345678, 8'hFF, 0,  1,   1,  8'h00, 0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{0, 0, 1, 32'h0,        8'h00, 0,  1,   1,  8'h00, 0,  0,  1, 32'h0});
        tbl.push_back(vec_t'{0, 0, 3, 32'h0,        8'h00, 0,  1,   1,  8'h00, 0,  0,  3, 32'h0});

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].we, tbl[k].sel, tbl[k].d, tbl[k].ack, tbl[k].clr, rdy);
            if (tbl[k].chk_rdy) begin
                tag = $sformatf("row%0d in_ready", k);
                check(tag, 32'(rdy), 32'(tbl[k].exp_rdy));
            end
            tag = $sformatf("row%0d full", k);
            check(tag, 32'(full), 32'(tbl[k].exp_full));
            tag = $sformatf("row%0d count", k);
            check(tag, 32'(count), 32'(tbl[k].exp_count));
            tag = $sformatf("row%0d overrun", k);
            check(tag, 32'(overrun), 32'(tbl[k].exp_ovr));
            tag = $sformatf("row%0d out[%0d]", k, tbl[k].chk_slot);
            check(tag, outs[tbl[k].chk_slot], tbl[k].chk_val);
        end

        // Randomized traffic: biased toward writes, sparse acks, occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic        r_r, r_we, r_c;
            logic [2:0]  r_s;
            logic [31:0] r_d;
            logic [7:0]  r_a;
            bit          exp_rdy;
            r_r  = ($urandom_range(0, 99) < 2);
            r_we = ($urandom_range(0, 99) < 65);
            r_s  = 3'($urandom_range(0, 7));
            r_d  = $urandom;
            r_a  = '0;
            for (int b = 0; b < 8; b++) r_a[b] = ($urandom_range(0, 99) < 20);
            r_c  = ($urandom_range(0, 99) < 10);
            exp_rdy = model_ready(r_s, r_a);
            drive(r_r, r_we, r_s, r_d, r_a, r_c, rdy);
            tag = $sformatf("rand%0d in_ready", n);
            check(tag, 32'(rdy), 32'(exp_rdy));
            tag = $sformatf("rand%0d full", n);
            check(tag, 32'(full), 32'(model_full_vec()));
            tag = $sformatf("rand%0d count", n);
            check(tag, 32'(count), 32'(model_count()));
            tag = $sformatf("rand%0d overrun", n);
            check(tag, 32'(overrun), 32'(m_ovr));
            for (int i = 0; i < 8; i++) begin
                tag = $sformatf("rand%0d out[%0d]", n, i);
                check(tag, outs[i], m_data[i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux32_1x8_slots.md
Name: demux32_1x8_slots

Overview:
Write-side counterpart of the 8:1 32-bit source mux used in the datapath. One 32-bit producer stream is steered by a 3-bit select into one of eight holding slots. Each slot holds its word until its consumer acknowledges it, and writes to occupied slots are back-pressured. It sits between a single result bus and eight independent consumers (register/latch destinations in the multicycle datapath).

Parameters:
WIDTH, 32, data width of the input and of every slot output (ports below are at the default).
NSLOTS, 8, number of destination slots; fixed at 8 (3-bit select); any other value is unsupported.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
in_data  input  32  word to be written.
sel  input  3  destination slot index: 0=a ... 7=h.
wr_en  input  1  write request, qualified by in_ready.
in_ready  output  1  combinational: the selected slot can accept this cycle.
ack  input  8  per-slot consume strobe; bit i frees slot i.
clr_err  input  1  clears the overrun flag.
out_a..out_h  output  32 each  slot contents, registered.
full  output  8  per-slot occupied flag, registered.
count  output  4  number of occupied slots (0..8), registered.
overrun  output  1  sticky flag: a write was attempted while in_ready was low.

Behaviour:
- Reset (sync, when reset=1 at the clock edge):
  - out_a..out_h=0, full=0, count=0, overrun=0.
  - Reset has priority over wr_en, ack and clr_err in the same cycle.
- in_ready = ~full[sel] | ack[sel]. It depends only on current-cycle inputs and state.
  - A full slot being acked in the same cycle accepts a new write (same-cycle refill).
- Write accepted (wr_en & in_ready):
  - On the edge, slot[sel] <= in_data and full[sel] <= 1.
  - Data and flag are visible 1 cycle after the accepting edge; no other slot changes.
- Write rejected (wr_en & ~in_ready):
  - Slot contents and full are unchanged; the word is dropped.
  - overrun <= 1.
- ack[i] with full[i]=1 and no accepted write to i: full[i] <= 0.
  - out_x keeps its last value; data is not cleared.
- ack[i] with full[i]=0: ignored. No error, no state change.
- Multiple ack bits in one cycle are all honoured independently.
- count tracks the next-state popcount of full, updated on the same edge as full.
  - Net change per cycle is in the range -8..+1.
- overrun:
  - set on a rejected write;
  - cleared by clr_err;
  - set wins if both happen in the same cycle;
  - otherwise held.
- sel/in_data with wr_en=0 have no effect (X on sel when idle is tolerated).
- No internal FSM beyond the per-slot 2-state flag (EMPTY <-> FULL):
  - EMPTY->FULL on an accepted write;
  - FULL->EMPTY on ack without a refill;
  - FULL->FULL on ack+write (data replaced) or on a rejected write (data kept).

Decomposition:
- Shared header holds:
  - constants SLOT_A..SLOT_H (3'd0..3'd7);
  - NSLOTS=8;
  - the WIDTH default.
- Sub-module demux_slot: one WIDTH-bit holding register plus full flag.
  - Inputs: clk, reset, wr (decoded and already qualified), din, ack.
  - Outputs: dout, full.
  - The top instantiates it 8 times and contains the sel decoder, in_ready mux, popcount and overrun logic.

Test Plan:
1. Reset, then write 0xDEADBEEF to sel=3 -> the next cycle shows out_d=0xDEADBEEF, full=8'b0000_1000, count=1; all other outputs remain 0.
2. Fill all 8 slots with 0x1..0x8, then wr_en to sel=5 with 0xFFFFFFFF -> in_ready=0; out_f stays 0x6; overrun=1 and stays set until clr_err is pulsed, then reads 0.
3. Slot 2 full with 0xAAAA0000; same cycle ack=8'b0000_0100 and write sel=2 0x5555 -> in_ready=1; next cycle out_c=0x5555, full[2]=1, count unchanged.
4. Slots 0..7 full; ack=8'hFF in one cycle -> next cycle full=0, count=0, out_a..out_h retain 0x1..0x8.
5. ack on an empty slot 6 while writing slot 1 -> only full[1] sets; count=1; overrun=0.
6. Assert reset mid-stream together with wr_en=1, sel=0, ack=8'hFF, clr_err=0 -> next cycle all outputs are 0; the write is not accepted.
